// File: rtl/vga_frame_probe.sv
// ---------------------------------------------------------------------------
// VgaFrameProbe (module vga_frame_probe)
//
// Receive-side probe for the VGA output path. It samples the same sync,
// blank and colour signals that leave the chip and measures them:
//   - h_total : pixels per line (last line closed before the frame edge)
//   - hs_w    : hsync width in pixels
//   - v_total : lines per frame
//   - vs_w    : vsync width in lines
//   - act_px  : active (non-blank) pixels per frame, 20-bit
//   - frame_cnt : number of frame_done pulses, 16-bit wrapping
//   - crc     : CRC-16-CCITT over active pixels (optional)
// All results land in shadow registers at a vsync leading edge and are read
// through a small registered port.
//
// Optional feature macro: VGA_PROBE_CRC_EN
//   defined   -> CRC-16-CCITT (0x1021, init 0xFFFF per frame) over the 12-bit
//                {r,g,b} of every active pixel, MSB first, readable at reg 7
//   undefined -> no CRC logic, reg 7 reads 0x0000
//
// Ports:
//   sys_clk_i     system clock
//   sys_reset_i   asynchronous active-low reset
//   pix_ce_i      pixel clock enable, all sampling happens on pix_ce_i=1
//   vga_h_i       horizontal sync (polarity HPOL)
//   vga_v_i       vertical sync (polarity VPOL)
//   is_blank_i    1 = outside active video
//   vga_r_i/g/b   4-bit colour components
//   rd_addr_i     register select
//   rd_data_o     registered read data, one cycle latency
//   frame_done_o  one-cycle pulse when the shadow registers update
//   locked_o      geometry identical on two consecutive frames
//
// Register map: 0 h_total, 1 hs_w, 2 v_total, 3 vs_w, 4 act_px[15:0],
//               5 act_px[19:16], 6 frame_cnt, 7 crc
// ---------------------------------------------------------------------------
module vga_frame_probe #(
    parameter bit HPOL = 1'b0,
    parameter bit VPOL = 1'b0,
    parameter int HW   = 12,
    parameter int VW   = 11
) (
    input  logic        sys_clk_i,
    input  logic        sys_reset_i,
    input  logic        pix_ce_i,
    input  logic        vga_h_i,
    input  logic        vga_v_i,
    input  logic        is_blank_i,
    input  logic [3:0]  vga_r_i,
    input  logic [3:0]  vga_g_i,
    input  logic [3:0]  vga_b_i,
    input  logic [2:0]  rd_addr_i,
    output logic [15:0] rd_data_o,
    output logic        frame_done_o,
    output logic        locked_o
);

    localparam logic [HW-1:0] H_MAX   = '1;
    localparam logic [VW-1:0] V_MAX   = '1;
    localparam logic [19:0]   ACT_MAX = '1;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        MEAS = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state_q;

    logic          smpH_q, smpV_q, smpBlank_q;
    logic          prvH_q, prvV_q;

    logic [HW-1:0] hCnt_q,   hCnt_d;
    logic [HW-1:0] hTotal_q, hTotal_d;
    logic [HW-1:0] hsCnt_q,  hsCnt_d;
    logic [HW-1:0] hsW_q,    hsW_d;
    logic [VW-1:0] vCnt_q,   vCnt_d;
    logic [VW-1:0] vsCnt_q,  vsCnt_d;
    logic [VW-1:0] vsW_q,    vsW_d;
    logic [19:0]   actCnt_q, actCnt_d;

    logic [HW-1:0] shH_q, shHs_q;
    logic [VW-1:0] shV_q, shVs_q;
    logic [19:0]   shAct_q;
    logic [15:0]   frameCnt_q;
    logic          frameDone_q;
    logic          locked_q;
    logic [15:0]   rdData_q;

    logic          hEdge, hTrail, vEdge, vTrail;
    logic          satNow;
    logic          closeFrame;
    logic [HW-1:0] hLast;
    logic          geomSame;

`ifdef VGA_PROBE_CRC_EN
    logic [11:0]   smpRgb_q;
    logic [15:0]   crc_q, crc_d;
    logic [15:0]   shCrc_q;

    // One CRC-16-CCITT step over a 12-bit pixel, MSB first.
    function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic [11:0] data);
        logic [15:0] c;
        c = crcIn;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`else
    logic          unusedRgb;

    // Colour inputs only feed the CRC, which is absent in this build.
    assign unusedRgb = ^{vga_r_i, vga_g_i, vga_b_i};
`endif

    // Input stage: keep the latest and the previous pix_ce sample. Syncs are
    // normalised so that 1 always means asserted. Blank resets to 1 so that
    // nothing is taken as active video before the first real sample.
    always_ff @(posedge sys_clk_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            smpH_q     <= 1'b0;
            smpV_q     <= 1'b0;
            smpBlank_q <= 1'b1;
            prvH_q     <= 1'b0;
            prvV_q     <= 1'b0;
`ifdef VGA_PROBE_CRC_EN
            smpRgb_q   <= 12'h000;
`endif
        end else if (pix_ce_i) begin
            smpH_q     <= vga_h_i ^ ~HPOL;
            smpV_q     <= vga_v_i ^ ~VPOL;
            smpBlank_q <= is_blank_i;
            prvH_q     <= smpH_q;
            prvV_q     <= smpV_q;
`ifdef VGA_PROBE_CRC_EN
            smpRgb_q   <= {vga_r_i, vga_g_i, vga_b_i};
`endif
        end
    end

    assign hEdge  = smpH_q & ~prvH_q;
    assign hTrail = ~smpH_q & prvH_q;
    assign vEdge  = smpV_q & ~prvV_q;
    assign vTrail = ~smpV_q & prvV_q;

    assign satNow = (hCnt_q == H_MAX) || (vCnt_q == V_MAX) ||
                    (hsCnt_q == H_MAX) || (vsCnt_q == V_MAX) ||
                    (actCnt_q == ACT_MAX);

    // When hsync and vsync rise together the closing line is the one that
    // belongs in the shadow, so take h_cnt directly instead of the stale
    // line register. That same coincident edge starts line 1 of the new
    // frame, which is why v_cnt restarts at 1 and is not bumped again.
    assign hLast    = hEdge ? hCnt_q : hTotal_q;
    assign geomSame = (hLast == shH_q) && (vCnt_q == shV_q) &&
                      (hsW_q == shHs_q) && (vsW_q == shVs_q);

    assign closeFrame = pix_ce_i && vEdge && !satNow && (state_q != SEEK);

    // Next-state logic of the working counters. Every counter saturates so
    // that a broken input stream is caught by the saturation check rather
    // than silently wrapping into a plausible value.
    always_comb begin
        hCnt_d   = hCnt_q;
        hTotal_d = hTotal_q;
        hsCnt_d  = hsCnt_q;
        hsW_d    = hsW_q;
        vCnt_d   = vCnt_q;
        vsCnt_d  = vsCnt_q;
        vsW_d    = vsW_q;
        actCnt_d = actCnt_q;
`ifdef VGA_PROBE_CRC_EN
        crc_d    = crc_q;
`endif
        if (pix_ce_i) begin
            if (hEdge) begin
                hTotal_d = hCnt_q;
                hCnt_d   = HW'(1);
            end else if (hCnt_q != H_MAX) begin
                hCnt_d = hCnt_q + 1'b1;
            end

            if (hTrail) begin
                hsW_d   = hsCnt_q;
                hsCnt_d = '0;
            end else if (smpH_q && (hsCnt_q != H_MAX)) begin
                hsCnt_d = hsCnt_q + 1'b1;
            end

            if (vEdge) begin
                vCnt_d = VW'(1);
            end else if (hEdge && (vCnt_q != V_MAX)) begin
                vCnt_d = vCnt_q + 1'b1;
            end

            if (vTrail) begin
                vsW_d   = vsCnt_q;
                vsCnt_d = '0;
            end else if (smpV_q && hEdge && (vsCnt_q != V_MAX)) begin
                vsCnt_d = vsCnt_q + 1'b1;
            end

            if (vEdge) begin
                actCnt_d = smpBlank_q ? 20'd0 : 20'd1;
            end else if (!smpBlank_q && (actCnt_q != ACT_MAX)) begin
                actCnt_d = actCnt_q + 1'b1;
            end

`ifdef VGA_PROBE_CRC_EN
            if (vEdge) begin
                crc_d = smpBlank_q ? 16'hFFFF : crcStep(16'hFFFF, smpRgb_q);
            end else if (!smpBlank_q) begin
                crc_d = crcStep(crc_q, smpRgb_q);
            end
`endif
        end
    end

    // Working counter registers.
    always_ff @(posedge sys_clk_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            hCnt_q   <= '0;
            hTotal_q <= '0;
            hsCnt_q  <= '0;
            hsW_q    <= '0;
            vCnt_q   <= '0;
            vsCnt_q  <= '0;
            vsW_q    <= '0;
            actCnt_q <= '0;
`ifdef VGA_PROBE_CRC_EN
            crc_q    <= 16'hFFFF;
`endif
        end else begin
            hCnt_q   <= hCnt_d;
            hTotal_q <= hTotal_d;
            hsCnt_q  <= hsCnt_d;
            hsW_q    <= hsW_d;
            vCnt_q   <= vCnt_d;
            vsCnt_q  <= vsCnt_d;
            vsW_q    <= vsW_d;
            actCnt_q <= actCnt_d;
`ifdef VGA_PROBE_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    // Frame state machine with the shadow registers and status outputs.
    // SEEK throws away the first partial frame, MEAS collects one full
    // frame, RUN publishes every frame and compares it with the previous
    // one. Saturation anywhere drops back to SEEK without publishing.
    always_ff @(posedge sys_clk_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            state_q     <= SEEK;
            shH_q       <= '0;
            shHs_q      <= '0;
            shV_q       <= '0;
            shVs_q      <= '0;
            shAct_q     <= '0;
            frameCnt_q  <= '0;
            frameDone_q <= 1'b0;
            locked_q    <= 1'b0;
`ifdef VGA_PROBE_CRC_EN
            shCrc_q     <= 16'h0000;
`endif
        end else begin
            frameDone_q <= 1'b0;
            if (closeFrame) begin
                shH_q       <= hLast;
                shHs_q      <= hsW_q;
                shV_q       <= vCnt_q;
                shVs_q      <= vsW_q;
                shAct_q     <= actCnt_q;
                frameCnt_q  <= frameCnt_q + 16'd1;
                frameDone_q <= 1'b1;
`ifdef VGA_PROBE_CRC_EN
                shCrc_q     <= crc_q;
`endif
            end
            if (pix_ce_i) begin
                case (state_q)
                    SEEK: begin
                        if (vEdge) begin
                            state_q <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (satNow) begin
                            state_q  <= SEEK;
                            locked_q <= 1'b0;
                        end else if (vEdge) begin
                            state_q  <= RUN;
                            locked_q <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (satNow) begin
                            state_q  <= SEEK;
                            locked_q <= 1'b0;
                        end else if (vEdge) begin
                            locked_q <= geomSame;
                        end
                    end
                    default: begin
                        state_q  <= SEEK;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Registered read port. It samples the shadows before they update, so a
    // read on the update cycle returns the previous frame's value.
    always_ff @(posedge sys_clk_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            rdData_q <= 16'h0000;
        end else begin
            case (rd_addr_i)
                3'd0:    rdData_q <= 16'(shH_q);
                3'd1:    rdData_q <= 16'(shHs_q);
                3'd2:    rdData_q <= 16'(shV_q);
                3'd3:    rdData_q <= 16'(shVs_q);
                3'd4:    rdData_q <= shAct_q[15:0];
                3'd5:    rdData_q <= {12'h000, shAct_q[19:16]};
                3'd6:    rdData_q <= frameCnt_q;
`ifdef VGA_PROBE_CRC_EN
                default: rdData_q <= shCrc_q;
`else
                default: rdData_q <= 16'h0000;
`endif
            endcase
        end
    end

    assign rd_data_o    = rdData_q;
    assign frame_done_o = frameDone_q;
    assign locked_o     = locked_q;

endmodule

// File: doc/vga_frame_probe.md
Name: vga_frame_probe

Overview:
- Receive-side counterpart of the VGA output path: sinks the same H/V/RGB/blank signals the top level drives off-chip.
- Measures line/frame timing, counts frames and (optionally) signs active pixel data with a CRC.
- Results are double-buffered at frame boundaries and readable over a small register port.
- Used on-chip for self-check and in simulation in place of the VPI pixel dump.

Parameters:
- HPOL, 0, hsync active level (0 = active-low).
- VPOL, 0, vsync active level.
- HW, 12, horizontal counter width.
- VW, 11, vertical counter width.

Ports:
- sys_clk  in  1  system clock (100 MHz).
- sys_reset  in  1  asynchronous, active-low reset.
- pix_ce  in  1  pixel-clock enable; all sampling happens only on cycles with pix_ce=1.
- vga_h  in  1  horizontal sync.
- vga_v  in  1  vertical sync.
- is_blank  in  1  1 = outside active video.
- vga_r, vga_g, vga_b  in  4 each  pixel colour.
- rd_addr  in  3  register select.
- rd_data  out  16  register data, registered, 1-cycle latency.
- frame_done  out  1  one-cycle pulse when the shadow registers update.
- locked  out  1  two consecutive frames had identical geometry.

Behaviour:
- Reset (sys_reset=0, async): all counters, shadows and the state machine clear; rd_data=0, frame_done=0, locked=0, state=SEEK.
- Input stage: on each pix_ce, register {vga_h, vga_v, is_blank, rgb}. Sync inputs are XORed with ~POL, so internally 1 = asserted.
- Edge detection compares against the previous pix_ce sample. Leading edge = 0→1 of the asserted level.
- h_cnt:
  - Increments every pix_ce and saturates at all-ones.
  - On an hsync leading edge, the line register takes h_cnt and h_cnt<=1.
  - Result: an 800-pixel line reads 800.
- hs_w: counts pix_ce while hsync is asserted. Latched and cleared on the trailing edge.
- v_cnt: increments on each hsync leading edge and saturates.
  - On a vsync leading edge: frame v_total<=v_cnt, then v_cnt<=1.
  - vs_w counts hsync leading edges while vsync is asserted.
- act_px: counts pix_ce samples with is_blank=0 per frame; 20-bit, saturating.
- FSM:
  - SEEK: wait for the first vsync leading edge, discard counts → MEAS.
  - MEAS: on the next vsync leading edge, copy working values to the shadow registers and pulse frame_done → RUN.
  - RUN: each vsync leading edge copies to shadow and pulses frame_done. Set locked if h_total, v_total, hs_w and vs_w all equal the previous frame's values; otherwise clear locked.
  - Any counter saturation in a frame → clear locked, return to SEEK, no frame_done for that frame.
- frame_cnt: 16-bit, increments on each frame_done and wraps 0xFFFF→0.
- Register map (rd_addr → rd_data, zero-extended):
  - 0: h_total
  - 1: hs_w
  - 2: v_total
  - 3: vs_w
  - 4: act_px[15:0]
  - 5: {12'b0, act_px[19:16]}
  - 6: frame_cnt
  - 7: crc
- Simultaneous events:
  - Read of an address on the same cycle its shadow updates returns the OLD value.
  - Hsync and vsync leading edges in the same sample: the line closes first and is counted into the frame being closed.
- pix_ce=0 cycles: all state holds; the rd_data port still operates every sys_clk.
- Reset mid-frame: everything aborts to SEEK; the first frame_done after reset comes at the second vsync leading edge.

Optional Feature:
- VGA_PROBE_CRC_EN defined:
  - CRC-16-CCITT (poly 0x1021), init 0xFFFF at each vsync leading edge.
  - Absorbs 12 bits {r,g,b}, MSB first, on each pix_ce with is_blank=0.
  - Final value is latched to shadow reg 7 with the other shadows.
- Not defined: no CRC logic; reg 7 reads 0x0000.

Test Plan:
- 640x480@60 stimulus (800x525, hsync 96 px, vsync 2 lines, active-low), pix_ce every 4th clock, 3 frames → first frame_done at the 2nd vsync edge; regs 0–5 read 800, 96, 525, 2, 0xB000, 0x0004; locked=1 after the 3rd edge.
- Reset sequence (sys_reset 1→0 at 40 ns for 50 ns) during frame 2 → all outputs 0 immediately; frame_cnt restarts; frame_done absent until 2 vsync edges after release.
- Change one line to 801 px in frame 3 → h_total updates, locked=0 for that frame, locked=1 again after 2 clean frames.
- hsync stuck inactive → h_cnt saturates at 4095 → SEEK, locked=0, no frame_done.
- Solid colour 0xFFF over 640x480 with VGA_PROBE_CRC_EN defined → reg 7 matches the golden software CRC and is identical on every frame; without the macro, reg 7=0.
- Read reg 6 on the frame_done cycle → returns the previous count; next read returns previous+1; frame_cnt wraps 0xFFFF→0x0000 when preloaded by force.
